switch_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the CPU's 8-bit `switches` port.
- Takes raw board switch levels, which are asynchronous and bouncy, and synchronises each bit into `clk`.
- Debounces each bit independently and delivers clean levels plus one-cycle rise/fall strobes.
- The CPU's memory-mapped I/O reads `sw_clean`; the strobes are available for future interrupt/event logic.

---
 rtl/cpu_io_pkg.sv | 13 +
 rtl/switch_conditioner_if.sv | 21 ++
 rtl/debounce_bit.sv | 68 ++++++
 rtl/switch_conditioner.sv | 36 +++
 tb/tb_switch_conditioner.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU I/O conditioning blocks.
// cnt_width() gives the debounce counter size for a given cycle count.
package cpu_io_pkg;

    localparam int SW_WIDTH                = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch bus between the board pins, the conditioner and the CPU I/O.
// The master drives raw levels; the slave (conditioner) returns clean levels and strobes.
interface switch_conditioner_if #(
    parameter int WIDTH = cpu_io_pkg::SW_WIDTH
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_any_change;

    modport master (
        output sw_raw,
        input  sw_clean, sw_rise, sw_fall, sw_any_change
    );

    modport slave (
        input  sw_raw,
        output sw_clean, sw_rise, sw_fall, sw_any_change
    );
endinterface

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchroniser, saturating debounce counter, clean level
// and registered one-cycle rise/fall strobes.
module debounce_bit
    import cpu_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $fatal(1, "debounce_bit: DEBOUNCE_CYCLES must be at least 1");
    end

    logic             sync1_q, sync2_q;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt==0 is IDLE, anything else is COUNTING toward a flip of the clean level.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            clean_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_raw_i;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the raw board switches into clean CPU-visible levels, one
// independent debouncer per bit, plus a combined change strobe.
module switch_conditioner
    import cpu_io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    switch_conditioner_if.slave  sw
);
    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw_raw_i (sw.sw_raw[gi]),
            .clean_o  (clean_w[gi]),
            .rise_o   (rise_w[gi]),
            .fall_o   (fall_w[gi])
        );
    end

    assign sw.sw_clean      = clean_w;
    assign sw.sw_rise       = rise_w;
    assign sw.sw_fall       = fall_w;
    // Strobes are already registered, so the OR lands in the same cycle.
    assign sw.sw_any_change = |(rise_w | fall_w);

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, monitors pop and compare.
// DUT A uses the simulation debounce length, DUT B the pass-through length of 1.
module tb_switch_conditioner;
    import cpu_io_pkg::*;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n, rst_b_n;
    logic mon_en = 1'b0;
    int   edge_n = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    switch_conditioner_if #(.WIDTH(SW_WIDTH)) a_if ();
    switch_conditioner_if #(.WIDTH(SW_WIDTH)) b_if ();

    switch_conditioner #(
        .WIDTH(SW_WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .sw(a_if)
    );

    switch_conditioner #(
        .WIDTH(SW_WIDTH), .DEBOUNCE_CYCLES(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .sw(b_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input int cyc, input string nm, input logic [7:0] c, input logic [7:0] r, input logic [7:0] f);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.clean = c; e.rise = r; e.fall = f; e.any = |(r | f);
        q_a.push_back(e);
    endtask

    task automatic exp_b(input int cyc, input string nm, input logic [7:0] c, input logic [7:0] r, input logic [7:0] f);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.clean = c; e.rise = r; e.fall = f; e.any = |(r | f);
        q_b.push_back(e);
    endtask

    task automatic cmp_entry(input string tag, input exp_t e, input logic [7:0] c,
                             input logic [7:0] r, input logic [7:0] f, input logic a);
        n_cmp++;
        if ({c, r, f, a} !== {e.clean, e.rise, e.fall, e.any}) begin
            n_err++;
            $display("FAIL %s/%s edge=%0d: got clean=%h rise=%h fall=%h any=%b, need clean=%h rise=%h fall=%h any=%b",
                     tag, e.name, e.cyc, c, r, f, a, e.clean, e.rise, e.fall, e.any);
        end else begin
            $display("ok   %s/%s edge=%0d: clean=%h rise=%h fall=%h any=%b",
                     tag, e.name, e.cyc, c, r, f, a);
        end
    endtask

    // Monitor A: compare scheduled cycles; any strobe on an unscheduled cycle is an error.
    always @(negedge clk) begin
        if (mon_en) begin
            while (q_a.size() > 0 && q_a[0].cyc < edge_n) begin
                ea = q_a.pop_front();
                n_cmp++; n_err++;
                $display("FAIL A/%s: expectation for edge %0d never sampled (now %0d), need clean=%h",
                         ea.name, ea.cyc, edge_n, ea.clean);
            end
            if (q_a.size() > 0 && q_a[0].cyc == edge_n) begin
                ea = q_a.pop_front();
                cmp_entry("A", ea, a_if.sw_clean, a_if.sw_rise, a_if.sw_fall, a_if.sw_any_change);
            end else if (a_if.sw_any_change !== 1'b0 || (a_if.sw_rise | a_if.sw_fall) !== 8'h00) begin
                n_cmp++; n_err++;
                $display("FAIL A/unexpected_pulse edge=%0d: got rise=%h fall=%h any=%b, need rise=00 fall=00 any=0",
                         edge_n, a_if.sw_rise, a_if.sw_fall, a_if.sw_any_change);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            while (q_b.size() > 0 && q_b[0].cyc < edge_n) begin
                eb = q_b.pop_front();
                n_cmp++; n_err++;
                $display("FAIL B/%s: expectation for edge %0d never sampled (now %0d), need clean=%h",
                         eb.name, eb.cyc, edge_n, eb.clean);
            end
            if (q_b.size() > 0 && q_b[0].cyc == edge_n) begin
                eb = q_b.pop_front();
                cmp_entry("B", eb, b_if.sw_clean, b_if.sw_rise, b_if.sw_fall, b_if.sw_any_change);
            end else if (b_if.sw_any_change !== 1'b0 || (b_if.sw_rise | b_if.sw_fall) !== 8'h00) begin
                n_cmp++; n_err++;
                $display("FAIL B/unexpected_pulse edge=%0d: got rise=%h fall=%h any=%b, need rise=00 fall=00 any=0",
                         edge_n, b_if.sw_rise, b_if.sw_fall, b_if.sw_any_change);
            end
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        a_if.sw_raw = 8'h00;
        b_if.sw_raw = 8'h00;
        tick(2);
        mon_en = 1'b1;
        exp_a(edge_n, "reset", 8'h00, 8'h00, 8'h00);
        exp_b(edge_n, "reset", 8'h00, 8'h00, 8'h00);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick(1);

        // Clean step on A, pass-through on B.
        base = edge_n;
        a_if.sw_raw = 8'h01;
        b_if.sw_raw = 8'hA5;
        exp_a(base + 5, "step_wait", 8'h00, 8'h00, 8'h00);
        exp_a(base + 6, "step_rise", 8'h01, 8'h01, 8'h00);
        exp_a(base + 7, "step_drop", 8'h01, 8'h00, 8'h00);
        exp_b(base + 2, "pass_wait", 8'h00, 8'h00, 8'h00);
        exp_b(base + 3, "pass_rise", 8'hA5, 8'hA5, 8'h00);
        exp_b(base + 4, "pass_drop", 8'hA5, 8'h00, 8'h00);
        tick(10);

        // Bounce on bit 3, then hold high.
        a_if.sw_raw = 8'h09; tick(1);
        a_if.sw_raw = 8'h01; tick(1);
        a_if.sw_raw = 8'h09; tick(1);
        a_if.sw_raw = 8'h01; tick(1);
        a_if.sw_raw = 8'h09;
        base = edge_n;
        exp_a(base + 5, "bounce_wait", 8'h01, 8'h00, 8'h00);
        exp_a(base + 6, "bounce_rise", 8'h09, 8'h08, 8'h00);
        exp_a(base + 7, "bounce_drop", 8'h09, 8'h00, 8'h00);
        tick(10);

        // Bit 7 high for three cycles only.
        base = edge_n;
        a_if.sw_raw = 8'h89;
        tick(3);
        a_if.sw_raw = 8'h09;
        exp_a(base + 4, "glitch_a", 8'h09, 8'h00, 8'h00);
        exp_a(base + 6, "glitch_b", 8'h09, 8'h00, 8'h00);
        exp_a(base + 8, "glitch_c", 8'h09, 8'h00, 8'h00);
        tick(10);

        // Fill low nibble, then swap nibbles in one step.
        base = edge_n;
        a_if.sw_raw = 8'h0F;
        exp_a(base + 6, "fill_rise", 8'h0F, 8'h06, 8'h00);
        tick(10);
        base = edge_n;
        a_if.sw_raw = 8'hF0;
        exp_a(base + 5, "multi_wait", 8'h0F, 8'h00, 8'h00);
        exp_a(base + 6, "multi_flip", 8'hF0, 8'hF0, 8'h0F);
        exp_a(base + 7, "multi_drop", 8'hF0, 8'h00, 8'h00);
        tick(10);

        // Reset while bits 0-3 are at cnt=2.
        a_if.sw_raw = 8'hFF;
        tick(4);
        rst_a_n = 1'b0;
        tick(1);
        exp_a(edge_n, "rst_mid", 8'h00, 8'h00, 8'h00);
        rst_a_n = 1'b1;
        base = edge_n;
        exp_a(base + 5, "rst_wait", 8'h00, 8'h00, 8'h00);
        exp_a(base + 6, "rst_rise", 8'hFF, 8'hFF, 8'h00);
        exp_a(base + 7, "rst_drop", 8'hFF, 8'h00, 8'h00);
        tick(12);

        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending expectations, need 0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
